// File: rtl/point_sched_pkg.sv
// Shared types and helpers for the point scheduler: FSM states, channel
// ordering inside a packed point record, and a word-extraction helper.
package point_sched_pkg;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      WAIT_MEM,
      LAUNCH,
      WAIT_DAC,
      LATCH,
      DWELL
   } sched_state_t;

   localparam int NUM_CH   = 5;
   localparam int CH_WIDTH = 16;

   // Channel positions counted from the MSB end of the record (x is highest).
   localparam int CH_X = 0;
   localparam int CH_Y = 1;
   localparam int CH_R = 2;
   localparam int CH_G = 3;
   localparam int CH_B = 4;

   function automatic logic [CH_WIDTH-1:0] channel_word(
      input logic [NUM_CH*CH_WIDTH-1:0] rec,
      input int                         ch
   );
      return rec[(NUM_CH-1-ch)*CH_WIDTH +: CH_WIDTH];
   endfunction

endpackage

// File: rtl/dwell_timer.sv
// Dwell timer: counts a loaded number of units, each PRESCALE clocks long.
// done marks the final cycle of the dwell, or the load cycle itself for zero.
module dwell_timer
   import point_sched_pkg::*;
#(
   parameter int PRESCALE = 100
) (
   input  logic        clock_in,
   input  logic        reset_in,
   input  logic        load,
   input  logic [15:0] units,
   output logic        done
);

   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

   logic [PW-1:0] pre_cnt;
   logic [15:0]   unit_cnt;
   logic          running;
   logic          last_tick;
   logic          pre_wrap;

   assign pre_wrap  = (pre_cnt == PW'(PRESCALE - 1));
   assign last_tick = running && (unit_cnt == 16'd1) && pre_wrap;
   assign done      = (load && (units == 16'd0)) || last_tick;

   always_ff @(posedge clock_in) begin
      if (reset_in) begin
         running  <= 1'b0;
         pre_cnt  <= '0;
         unit_cnt <= '0;
      end else if (load) begin
         running  <= (units != 16'd0);
         pre_cnt  <= '0;
         unit_cnt <= units;
      end else if (running) begin
         if (last_tick) begin
            running <= 1'b0;
         end else if (pre_wrap) begin
            pre_cnt  <= '0;
            unit_cnt <= unit_cnt - 16'd1;
         end else begin
            pre_cnt <= pre_cnt + PW'(1);
         end
      end
   end

endmodule

// File: rtl/point_scheduler.sv
// Walks the point list: fetch a record, launch all five DAC transmitters,
// wait for them, pulse LDAC, dwell, then advance (wrapping at frame end).
module point_scheduler
   import point_sched_pkg::*;
#(
   parameter int ADDR_WIDTH  = 12,
   parameter int DAC_WIDTH   = 16,
   parameter int PRESCALE    = 100,
   parameter int LDAC_CYCLES = 2
) (
   input  logic                          clock_in,
   input  logic                          reset_in,
   input  logic                          enable,
   input  logic [ADDR_WIDTH-1:0]         num_points,
   input  logic [15:0]                   frame_delay,
   output logic                          mem_req,
   output logic [ADDR_WIDTH-1:0]         mem_addr,
   input  logic                          mem_valid,
   input  logic [NUM_CH*DAC_WIDTH-1:0]   mem_data,
   output logic [NUM_CH*DAC_WIDTH-1:0]   dac_data,
   output logic                          dac_start,
   input  logic [NUM_CH-1:0]             dac_busy,
   output logic                          ldac_n,
   output logic                          frame_done,
   output logic                          busy
);

   localparam int LW = (LDAC_CYCLES > 1) ? $clog2(LDAC_CYCLES) : 1;

   sched_state_t          state;
   sched_state_t          next_state;
   sched_state_t          exit_state;
   logic [ADDR_WIDTH-1:0] index;
   logic [ADDR_WIDTH:0]   index_plus;
   logic                  wrap;
   logic [LW-1:0]         ldac_cnt;
   logic                  latch_last;
   logic                  dac_first;
   logic                  timer_done;
   logic                  dwell_exit;

   assign index_plus = {1'b0, index} + {{ADDR_WIDTH{1'b0}}, 1'b1};
   assign wrap       = (index_plus >= {1'b0, num_points});
   assign latch_last = (state == LATCH) && (ldac_cnt == LW'(LDAC_CYCLES - 1));
   assign dwell_exit = timer_done && (latch_last || (state == DWELL));
   assign exit_state = (enable && (num_points != '0)) ? FETCH : IDLE;
   assign mem_addr   = index;

   // The timer is loaded on the last LATCH cycle so a zero dwell exits there.
   dwell_timer #(
      .PRESCALE(PRESCALE)
   ) u_dwell_timer (
      .clock_in (clock_in),
      .reset_in (reset_in),
      .load     (latch_last),
      .units    (frame_delay),
      .done     (timer_done)
   );

   always_ff @(posedge clock_in) begin
      if (reset_in) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // busy from the transmitters lags the start strobe by a cycle, hence dac_first.
   always_comb begin
      next_state = state;
      case (state)
         IDLE:     if (enable && (num_points != '0)) next_state = FETCH;
         FETCH:    next_state = WAIT_MEM;
         WAIT_MEM: if (mem_valid) next_state = LAUNCH;
         LAUNCH:   next_state = WAIT_DAC;
         WAIT_DAC: if (!dac_first && (dac_busy == '0)) next_state = LATCH;
         LATCH:    if (latch_last) next_state = timer_done ? exit_state : DWELL;
         DWELL:    if (timer_done) next_state = exit_state;
         default:  next_state = IDLE;
      endcase
   end

   always_comb begin
      mem_req   = (state == FETCH);
      dac_start = (state == LAUNCH);
      ldac_n    = (state != LATCH);
      busy      = (state != IDLE);
   end

   always_ff @(posedge clock_in) begin
      if (reset_in) begin
         index      <= '0;
         ldac_cnt   <= '0;
         dac_first  <= 1'b0;
         dac_data   <= '0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= dwell_exit && wrap;
         dac_first  <= (state == LAUNCH);
         ldac_cnt   <= (state == LATCH) ? ldac_cnt + LW'(1) : '0;
         if (dwell_exit) begin
            index <= wrap ? '0 : index_plus[ADDR_WIDTH-1:0];
         end
         if ((state == WAIT_MEM) && mem_valid) begin
            dac_data <= mem_data;
         end
      end
   end

endmodule

// File: tb/tb_point_scheduler.sv
// Bench for point_scheduler: memory and DAC models, an event log, and a
// timing model derived from the point sequencing rules.
module tb_point_scheduler;
   import point_sched_pkg::*;

   localparam int AW = 12;
   localparam int DW = 16;
   localparam int PS = 4;
   localparam int LC = 2;

   logic            clock_in;
   logic            reset_in;
   logic            enable;
   logic [AW-1:0]   num_points;
   logic [15:0]     frame_delay;
   logic            mem_req;
   logic [AW-1:0]   mem_addr;
   logic            mem_valid;
   logic [5*DW-1:0] mem_data;
   logic [5*DW-1:0] dac_data;
   logic            dac_start;
   logic [4:0]      dac_busy;
   logic            ldac_n;
   logic            frame_done;
   logic            busy;

   point_scheduler #(
      .ADDR_WIDTH(AW), .DAC_WIDTH(DW), .PRESCALE(PS), .LDAC_CYCLES(LC)
   ) dut (
      .clock_in(clock_in), .reset_in(reset_in), .enable(enable),
      .num_points(num_points), .frame_delay(frame_delay),
      .mem_req(mem_req), .mem_addr(mem_addr), .mem_valid(mem_valid),
      .mem_data(mem_data), .dac_data(dac_data), .dac_start(dac_start),
      .dac_busy(dac_busy), .ldac_n(ldac_n), .frame_done(frame_done),
      .busy(busy)
   );

   initial clock_in = 1'b0;
   always #5 clock_in = ~clock_in;

   typedef struct {
      int np;
      int fd;
      int lat;
      int dlen;
      int nf;
      int exp_period;
   } vec_t;

   vec_t            vecs[4];
   int              n_compared;
   int              n_mismatched;
   int              cyc;
   int              mem_lat;
   int              dac_len[5];
   logic [5*DW-1:0] mem[16];
   int              pend_due;
   logic [AW-1:0]   pend_addr;
   int              start_cyc;
   int              fetch_cyc[$];
   int              fetch_addr[$];
   int              launch_cyc[$];
   logic [5*DW-1:0] launch_data[$];
   int              ldac_cyc[$];
   int              done_cyc[$];
   int              overlap_err;
   int              busy_seen;

   // Memory and transmitter models plus the event log, one step per cycle.
   initial begin
      cyc = 0; pend_due = -1; start_cyc = -1000; pend_addr = '0;
      mem_valid = 1'b0; mem_data = '0; dac_busy = '0;
      forever begin
         @(posedge clock_in);
         #1;
         cyc++;
         if (reset_in) begin
            pend_due = -1; start_cyc = -1000;
            mem_valid = 1'b0; dac_busy = '0;
         end else begin
            if (mem_req) begin
               fetch_cyc.push_back(cyc);
               fetch_addr.push_back(int'(mem_addr));
               pend_due  = cyc + mem_lat;
               pend_addr = mem_addr;
            end
            if (dac_start) begin
               launch_cyc.push_back(cyc);
               launch_data.push_back(dac_data);
               start_cyc = cyc;
            end
            if (!ldac_n) begin
               ldac_cyc.push_back(cyc);
               if (dac_busy != '0) overlap_err++;
            end
            if (frame_done) done_cyc.push_back(cyc);
            if (busy) busy_seen++;
            mem_valid = (cyc == pend_due);
            mem_data  = mem_valid ? mem[pend_addr[3:0]] : {$urandom, $urandom, 16'hdead};
            for (int ch = 0; ch < 5; ch++)
               dac_busy[ch] = (cyc > start_cyc) && (cyc <= start_cyc + dac_len[ch]);
         end
      end
   end

   task automatic check_output(input string name, input logic [79:0] actual,
                               input logic [79:0] expected);
      n_compared++;
      if (actual !== expected) begin
         n_mismatched++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
      end
   endtask

   task automatic clear_logs();
      fetch_cyc.delete(); fetch_addr.delete(); launch_cyc.delete();
      launch_data.delete(); ldac_cyc.delete(); done_cyc.delete();
      overlap_err = 0; busy_seen = 0;
   endtask

   task automatic do_reset();
      @(negedge clock_in);
      enable = 1'b0; reset_in = 1'b1;
      repeat (2) @(negedge clock_in);
      reset_in = 1'b0;
   endtask

   task automatic fill_mem();
      for (int j = 0; j < 16; j++) mem[j] = {$urandom, $urandom, 16'($urandom)};
   endtask

   task automatic set_lens(input int l0, input int l1, input int l2, input int l3, input int l4);
      dac_len[0] = l0; dac_len[1] = l1; dac_len[2] = l2; dac_len[3] = l3; dac_len[4] = l4;
   endtask

   // Runs until nf points have been fetched, then drops enable and lets it drain.
   task automatic apply_stimulus(input int np, input int fd, input int lat, input int nf);
      int t;
      do_reset();
      clear_logs();
      mem_lat = lat; num_points = AW'(np); frame_delay = 16'(fd); enable = 1'b1;
      t = 0;
      while (fetch_cyc.size() < nf && t < 3000) begin
         @(negedge clock_in);
         t++;
      end
      enable = 1'b0;
      check_output("fetch_timeout", 80'(t < 3000), 80'd1);
      t = 0;
      @(negedge clock_in);
      while (busy && t < 3000) begin
         @(negedge clock_in);
         t++;
      end
      check_output("drain_timeout", 80'(t < 3000), 80'd1);
      repeat (20) @(negedge clock_in);
   endtask

   // Expected timing: launch lat+1 after fetch; LATCH max(busy,1)+2 after launch.
   task automatic check_run(input int np, input int fd, input int lat, input int nf,
                            input int exp_period, input string tag);
      int deff;
      int n;
      int exp_done[$];
      deff = 1;
      for (int ch = 0; ch < 5; ch++) if (dac_len[ch] > deff) deff = dac_len[ch];
      check_output({tag, "_fetch_count"}, 80'(fetch_cyc.size()), 80'(nf));
      check_output({tag, "_launch_count"}, 80'(launch_cyc.size()), 80'(nf));
      check_output({tag, "_ldac_count"}, 80'(ldac_cyc.size()), 80'(LC * nf));
      n = fetch_cyc.size();
      if (launch_cyc.size() < n) n = launch_cyc.size();
      if (ldac_cyc.size() / 2 < n) n = ldac_cyc.size() / 2;
      for (int i = 0; i < n; i++) begin
         check_output({tag, "_addr"}, 80'(fetch_addr[i]), 80'(i % np));
         check_output({tag, "_launch_lat"}, 80'(launch_cyc[i] - fetch_cyc[i]), 80'(lat + 1));
         check_output({tag, "_data"}, launch_data[i], mem[i % np]);
         check_output({tag, "_ldac_first"}, 80'(ldac_cyc[2*i] - launch_cyc[i]), 80'(deff + 2));
         check_output({tag, "_ldac_second"}, 80'(ldac_cyc[2*i+1] - launch_cyc[i]), 80'(deff + 3));
         if (i > 0)
            check_output({tag, "_period"}, 80'(fetch_cyc[i] - fetch_cyc[i-1]), 80'(exp_period));
         if (i % np == np - 1) exp_done.push_back(launch_cyc[i] + deff + 4 + fd * PS);
      end
      check_output({tag, "_done_count"}, 80'(done_cyc.size()), 80'(exp_done.size()));
      for (int j = 0; j < exp_done.size() && j < done_cyc.size(); j++)
         check_output({tag, "_done_cyc"}, 80'(done_cyc[j]), 80'(exp_done[j]));
      check_output({tag, "_ldac_while_busy"}, 80'(overlap_err), 80'd0);
      check_output({tag, "_idle_at_end"}, 80'(busy), 80'd0);
   endtask

   initial begin
      int np, fd, lat, nf, deff, t, slow_gap, fast_gap;
      logic [79:0] rec;
      n_compared = 0; n_mismatched = 0;
      reset_in = 1'b1; enable = 1'b0; num_points = '0; frame_delay = '0;
      mem_lat = 2; set_lens(0, 0, 0, 0, 0);
      fill_mem();

      do_reset();
      check_output("rst_mem_req", 80'(mem_req), 80'd0);
      check_output("rst_mem_addr", 80'(mem_addr), 80'd0);
      check_output("rst_dac_data", dac_data, 80'd0);
      check_output("rst_dac_start", 80'(dac_start), 80'd0);
      check_output("rst_ldac_n", 80'(ldac_n), 80'd1);
      check_output("rst_frame_done", 80'(frame_done), 80'd0);
      check_output("rst_busy", 80'(busy), 80'd0);

      // period = lat + max(busy,1) + 2 (latch) + 3 (fetch, launch, first wait) + fd*PS
      vecs[0] = '{np: 3, fd: 1, lat: 2, dlen: 3, nf: 4, exp_period: 14};
      vecs[1] = '{np: 1, fd: 0, lat: 1, dlen: 0, nf: 3, exp_period: 7};
      vecs[2] = '{np: 2, fd: 2, lat: 3, dlen: 5, nf: 3, exp_period: 21};
      vecs[3] = '{np: 4, fd: 0, lat: 2, dlen: 1, nf: 5, exp_period: 8};
      for (int v = 0; v < 4; v++) begin
         fill_mem();
         set_lens(vecs[v].dlen, vecs[v].dlen, vecs[v].dlen, vecs[v].dlen, vecs[v].dlen);
         apply_stimulus(vecs[v].np, vecs[v].fd, vecs[v].lat, vecs[v].nf);
         check_run(vecs[v].np, vecs[v].fd, vecs[v].lat, vecs[v].nf, vecs[v].exp_period, "table");
      end

      for (int r = 0; r < 6; r++) begin
         fill_mem();
         np  = int'($urandom_range(1, 4));
         fd  = int'($urandom_range(0, 2));
         lat = int'($urandom_range(1, 3));
         nf  = np + 2;
         set_lens(int'($urandom_range(0, 6)), int'($urandom_range(0, 6)), int'($urandom_range(0, 6)),
                  int'($urandom_range(0, 6)), int'($urandom_range(0, 6)));
         deff = 1;
         for (int ch = 0; ch < 5; ch++) if (dac_len[ch] > deff) deff = dac_len[ch];
         apply_stimulus(np, fd, lat, nf);
         check_run(np, fd, lat, nf, lat + deff + 5 + fd * PS, "rand");
      end

      // One slow channel holds off LDAC by exactly its extra busy time.
      rec = 80'h1111_2222_3333_4444_5555;
      fill_mem();
      mem[0] = rec;
      set_lens(3, 3, 13, 3, 3);
      apply_stimulus(1, 0, 2, 2);
      check_run(1, 0, 2, 2, 2 + 13 + 5, "slow");
      check_output("rec_held", dac_data, rec);
      check_output("rec_red", 80'(channel_word(dac_data, CH_R)), 80'h3333);
      check_output("rec_x", 80'(channel_word(dac_data, CH_X)), 80'h1111);
      slow_gap = (ldac_cyc.size() > 0 && launch_cyc.size() > 0) ? ldac_cyc[0] - launch_cyc[0] : -1;
      set_lens(3, 3, 3, 3, 3);
      apply_stimulus(1, 0, 2, 2);
      fast_gap = (ldac_cyc.size() > 0 && launch_cyc.size() > 0) ? ldac_cyc[0] - launch_cyc[0] : -1;
      check_output("slow_delay_diff", 80'(slow_gap - fast_gap), 80'd10);

      // Enable dropped in WAIT_DAC: point still latches and dwells, then idles.
      do_reset(); clear_logs();
      fill_mem(); set_lens(5, 5, 5, 5, 5);
      mem_lat = 2; num_points = AW'(3); frame_delay = 16'd1; enable = 1'b1;
      t = 0;
      while (launch_cyc.size() < 1 && t < 500) begin @(negedge clock_in); t++; end
      @(negedge clock_in);
      enable = 1'b0;
      t = 0;
      while (busy && t < 500) begin @(negedge clock_in); t++; end
      check_output("drop_drain_timeout", 80'(t < 500), 80'd1);
      check_output("drop_ldac_cycles", 80'(ldac_cyc.size()), 80'(LC));
      check_output("drop_dwell_len", 80'(busy_seen), 80'(1 + 2 + 1 + 6 + LC + PS));
      repeat (30) @(negedge clock_in);
      check_output("drop_fetch_count", 80'(fetch_cyc.size()), 80'd1);
      check_output("drop_busy", 80'(busy), 80'd0);

      // Reset during the second point's LATCH.
      do_reset(); clear_logs();
      fill_mem(); set_lens(2, 2, 2, 2, 2);
      mem_lat = 1; num_points = AW'(2); frame_delay = 16'd1; enable = 1'b1;
      t = 0;
      while (ldac_cyc.size() < 3 && t < 500) begin @(negedge clock_in); t++; end
      check_output("latch_wait_timeout", 80'(t < 500), 80'd1);
      check_output("latch_addr_before", 80'(mem_addr), 80'd1);
      reset_in = 1'b1;
      @(negedge clock_in);
      check_output("abort_ldac_n", 80'(ldac_n), 80'd1);
      check_output("abort_dac_start", 80'(dac_start), 80'd0);
      check_output("abort_mem_addr", 80'(mem_addr), 80'd0);
      check_output("abort_busy", 80'(busy), 80'd0);
      reset_in = 1'b0; enable = 1'b0;

      // num_points=0 keeps the scheduler idle.
      do_reset(); clear_logs();
      num_points = '0; frame_delay = 16'd1; enable = 1'b1;
      repeat (100) @(negedge clock_in);
      check_output("zero_np_fetch", 80'(fetch_cyc.size()), 80'd0);
      check_output("zero_np_launch", 80'(launch_cyc.size()), 80'd0);
      check_output("zero_np_busy", 80'(busy_seen), 80'd0);
      enable = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
